ins_fetch: RTL and testbench

INS_FETCH -- requirements
Module: ins_fetch

---
 rtl/ins_fetch_pkg.sv | 31 +++
 rtl/ins_next_pc.sv | 45 ++++
 rtl/ins_fetch.sv | 105 ++++++++++
 tb/tb_ins_fetch.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: sizes, opcodes, FSM states.
package ins_fetch_pkg;

  localparam int WORD_SIZE_DEF  = 8;
  localparam int INDEX_SIZE_DEF = 4;

  // Opcodes live in ir[7:4]
  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_MOVR = 4'b0100;
  localparam logic [3:0] OP_MOVA = 4'b0101;
  localparam logic [3:0] OP_JZR  = 4'b0110;
  localparam logic [3:0] OP_JZI  = 4'b0111;
  localparam logic [3:0] OP_JNR  = 4'b1000;
  localparam logic [3:0] OP_ILL  = 4'b1001;
  localparam logic [3:0] OP_JNI  = 4'b1010;
  localparam logic [3:0] OP_SHL  = 4'b1011;
  localparam logic [3:0] OP_SHR  = 4'b1100;
  localparam logic [3:0] OP_LDI  = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALTED
  } state_t;

endpackage

// File: rtl/ins_next_pc.sv
// Next-PC resolution: sequential advance or conditional jump target.
module ins_next_pc
  import ins_fetch_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int INDEX_SIZE = INDEX_SIZE_DEF
) (
  input  logic [WORD_SIZE-1:0]  ir,
  input  logic [INDEX_SIZE-1:0] prog_count,
  input  logic [WORD_SIZE-1:0]  reg_data,
  input  logic                  acc_zero,
  input  logic                  acc_neg,
  output logic [INDEX_SIZE-1:0] next_pc,
  output logic                  taken
);

  logic [3:0]            opcode;
  logic [INDEX_SIZE-1:0] seq_pc;
  logic [INDEX_SIZE-1:0] imm_tgt;
  logic [INDEX_SIZE-1:0] reg_tgt;
  logic                  unused_bits;

  assign opcode  = ir[7:4];
  // Natural overflow of the PC width gives the wrap from last address to 0
  assign seq_pc  = prog_count + INDEX_SIZE'(1);
  assign imm_tgt = INDEX_SIZE'(ir[3:0]);
  assign reg_tgt = INDEX_SIZE'(reg_data[3:0]);

  // Only the low nibbles carry targets; wider words are ignored here
  assign unused_bits = ^{ir, reg_data};

  // Pick the jump target when the flag condition holds, else fall through
  always_comb begin
    taken   = 1'b0;
    next_pc = seq_pc;
    case (opcode)
      OP_JZR: if (acc_zero) begin taken = 1'b1; next_pc = reg_tgt; end
      OP_JZI: if (acc_zero) begin taken = 1'b1; next_pc = imm_tgt; end
      OP_JNR: if (acc_neg)  begin taken = 1'b1; next_pc = reg_tgt; end
      OP_JNI: if (acc_neg)  begin taken = 1'b1; next_pc = imm_tgt; end
      default: ;
    endcase
  end

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch/issue sequencer with valid/ready handshake to the datapath.
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter int WORD_SIZE  = WORD_SIZE_DEF,
  parameter int INDEX_SIZE = INDEX_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [INDEX_SIZE-1:0] prog_count,
  input  logic [WORD_SIZE-1:0]  ins_val,
  output logic [WORD_SIZE-1:0]  ir,
  output logic                  ins_valid,
  input  logic                  ins_ready,
  output logic [3:0]            reg_sel,
  input  logic [WORD_SIZE-1:0]  reg_data,
  input  logic                  acc_zero,
  input  logic                  acc_neg,
  output logic                  halted,
  output logic                  branch_taken,
  output logic                  illegal_op
);

  state_t                state, state_n;
  logic [INDEX_SIZE-1:0] pc_n;
  logic [INDEX_SIZE-1:0] jump_pc;
  logic                  jump_taken;
  logic                  ir_ld;
  logic                  hs;

  assign reg_sel = ir[3:0];
  assign hs      = (state == S_ISSUE) && ins_ready;

  ins_next_pc #(
    .WORD_SIZE  (WORD_SIZE),
    .INDEX_SIZE (INDEX_SIZE)
  ) u_next_pc (
    .ir         (ir),
    .prog_count (prog_count),
    .reg_data   (reg_data),
    .acc_zero   (acc_zero),
    .acc_neg    (acc_neg),
    .next_pc    (jump_pc),
    .taken      (jump_taken)
  );

  // State register; reset drops straight to IDLE so a pending issue is lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state, PC/IR update controls and the status outputs
  always_comb begin
    state_n      = state;
    pc_n         = prog_count;
    ir_ld        = 1'b0;
    ins_valid    = 1'b0;
    halted       = 1'b0;
    branch_taken = 1'b0;
    illegal_op   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          pc_n    = '0;
          state_n = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_ld   = 1'b1;
        state_n = (ins_val[7:4] == OP_HALT) ? S_HALTED : S_ISSUE;
      end
      S_ISSUE: begin
        ins_valid = 1'b1;
        if (hs) begin
          pc_n         = jump_pc;
          branch_taken = jump_taken;
          illegal_op   = (ir[7:4] == OP_ILL);
          state_n      = S_FETCH;
        end
      end
      S_HALTED: begin
        halted = 1'b1;
        if (start) begin
          pc_n    = '0;
          state_n = S_FETCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // PC and IR hold steady through ISSUE until the handshake moves them on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_count <= '0;
      ir         <= '0;
    end else begin
      prog_count <= pc_n;
      if (ir_ld) ir <= ins_val;
    end
  end

endmodule

// File: tb/tb_ins_fetch.sv
// Scoreboard bench for ins_fetch: small program memory, flag tables, handshake checks.
module tb_ins_fetch;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [3:0] prog_count;
  logic [7:0] ins_val;
  logic [7:0] ir;
  logic       ins_valid;
  logic       ins_ready = 1'b1;
  logic [3:0] reg_sel;
  logic [7:0] reg_data;
  logic       acc_zero, acc_neg;
  logic       halted, branch_taken, illegal_op;

  logic [7:0] mem      [16];
  logic [7:0] regs     [16];
  logic       zero_tbl [16];
  logic       neg_tbl  [16];

  typedef struct {
    logic [3:0] pc;
    logic [7:0] ir;
    logic       tk;
    logic       il;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   hs_count = 0;

  assign ins_val  = mem[prog_count];
  assign reg_data = regs[reg_sel];
  assign acc_zero = zero_tbl[prog_count];
  assign acc_neg  = neg_tbl[prog_count];

  always #5 clk = ~clk;

  ins_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .prog_count   (prog_count),
    .ins_val      (ins_val),
    .ir           (ir),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .reg_sel      (reg_sel),
    .reg_data     (reg_data),
    .acc_zero     (acc_zero),
    .acc_neg      (acc_neg),
    .halted       (halted),
    .branch_taken (branch_taken),
    .illegal_op   (illegal_op)
  );

  // One clock: observe at negedge (scoreboard pop on handshake), then return at posedge+1
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      if (ins_valid === 1'b1 && ins_ready === 1'b1) begin
        hs_count++;
        hs_cyc.push_back(cyc);
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_handshake: pc=%0d ir=%h", prog_count, ir);
        end else begin
          e = sb.pop_front();
          if ({prog_count, ir, reg_sel, branch_taken, illegal_op} !==
              {e.pc, e.ir, e.ir[3:0], e.tk, e.il}) begin
            bad++;
            $display("FAIL handshake: got pc=%0d ir=%h sel=%h tk=%b il=%b exp pc=%0d ir=%h sel=%h tk=%b il=%b",
                     prog_count, ir, reg_sel, branch_taken, illegal_op,
                     e.pc, e.ir, e.ir[3:0], e.tk, e.il);
          end
        end
      end else begin
        total++;
        if (branch_taken !== 1'b0 || illegal_op !== 1'b0) begin
          bad++;
          $display("FAIL stray_pulse: got tk=%b il=%b exp 0 0", branch_taken, illegal_op);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic exp(input logic [3:0] pc, input logic [7:0] irv, input logic tk, input logic il);
    exp_t e;
    e.pc = pc; e.ir = irv; e.tk = tk; e.il = il;
    sb.push_back(e);
  endtask

  task automatic clear_env();
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'hF0; regs[i] = 8'h00; zero_tbl[i] = 1'b0; neg_tbl[i] = 1'b0;
    end
    sb.delete();
    hs_cyc.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_halt(input logic [3:0] halt_pc, input string name);
    int n = 0;
    while (halted !== 1'b1 && n < 200) begin tick(); n++; end
    total++;
    if (halted !== 1'b1) begin bad++; $display("FAIL %s_halt_timeout: got halted=%b exp 1", name, halted); end
    total++;
    if (prog_count !== halt_pc || ins_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_halt_state: got pc=%0d valid=%b exp pc=%0d valid=0", name, prog_count, ins_valid, halt_pc);
    end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL %s_missing_handshakes: got %0d left exp 0", name, sb.size()); end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    total++;
    if ({prog_count, ir, ins_valid, halted, branch_taken, illegal_op} !== 18'd0) begin
      bad++;
      $display("FAIL reset_async: got pc=%0d ir=%h v=%b h=%b tk=%b il=%b exp all 0",
               prog_count, ir, ins_valid, halted, branch_taken, illegal_op);
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ins_valid !== 1'b0 || halted !== 1'b0 || prog_count !== 4'd0) begin
        bad++;
        $display("FAIL reset_idle: got v=%b h=%b pc=%0d exp 0 0 0", ins_valid, halted, prog_count);
      end
    end
  endtask

  task automatic test_linear();
    logic [3:0] ops [12];
    ops = '{4'hD, 4'h5, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hC, 4'h0, 4'hD, 4'h1, 4'h2};
    clear_env();
    for (int i = 0; i < 12; i++) begin
      mem[i] = {ops[i], 4'(i)};
      if (i == 0) mem[i] = 8'b11011000;
      exp(4'(i), mem[i], 1'b0, 1'b0);
    end
    mem[12] = 8'b11110000;
    // start held over the FETCH cycle as well; it must be ignored there
    start = 1'b1;
    tick();
    total++;
    if (ins_valid !== 1'b0) begin bad++; $display("FAIL linear_latency1: got valid=%b exp 0", ins_valid); end
    tick();
    start = 1'b0;
    total++;
    if (ins_valid !== 1'b1 || prog_count !== 4'd0) begin
      bad++;
      $display("FAIL linear_latency2: got valid=%b pc=%0d exp 1 0", ins_valid, prog_count);
    end
    wait_halt(4'd12, "linear");
    total++;
    if (hs_cyc.size() !== 12) begin bad++; $display("FAIL linear_count: got %0d exp 12", hs_cyc.size()); end
    for (int i = 1; i < hs_cyc.size(); i++) begin
      total++;
      if (hs_cyc[i] - hs_cyc[i-1] !== 2) begin
        bad++;
        $display("FAIL linear_throughput: got gap=%0d exp 2", hs_cyc[i] - hs_cyc[i-1]);
      end
    end
  endtask

  task automatic test_jump_zero();
    clear_env();
    mem[0] = 8'h10; mem[1] = 8'h21; mem[2] = 8'h32; mem[3] = 8'h62;
    mem[5] = 8'h45; mem[6] = 8'h56; mem[7] = 8'hB7; mem[8] = 8'h7A;
    regs[2] = 8'hA5;  // only the low nibble (5) is a target
    for (int i = 0; i < 16; i++) zero_tbl[i] = 1'b1;
    exp(0, 8'h10, 0, 0); exp(1, 8'h21, 0, 0); exp(2, 8'h32, 0, 0); exp(3, 8'h62, 1, 0);
    exp(5, 8'h45, 0, 0); exp(6, 8'h56, 0, 0); exp(7, 8'hB7, 0, 0); exp(8, 8'h7A, 1, 0);
    pulse_start();
    wait_halt(4'd10, "jump_zero");
  endtask

  task automatic test_jump_neg();
    clear_env();
    mem[0] = 8'hC0; mem[1] = 8'hD1; mem[2] = 8'h02; mem[3] = 8'h13;
    mem[4] = 8'h81; mem[5] = 8'hAC;
    regs[1] = 8'h06;
    zero_tbl[4] = 1'b1;  // zero flag must not steer a JNR
    neg_tbl[5]  = 1'b1;
    exp(0, 8'hC0, 0, 0); exp(1, 8'hD1, 0, 0); exp(2, 8'h02, 0, 0); exp(3, 8'h13, 0, 0);
    exp(4, 8'h81, 0, 0); exp(5, 8'hAC, 1, 0);
    pulse_start();
    wait_halt(4'd12, "jump_neg");
  endtask

  task automatic test_wrap_illegal_self();
    int base;
    int n = 0;
    clear_env();
    mem[0] = 8'h7F; mem[1] = 8'h90; mem[2] = 8'hA2; mem[15] = 8'h00;
    zero_tbl[0] = 1'b1;
    neg_tbl[2]  = 1'b1;
    exp(0, 8'h7F, 1, 0); exp(15, 8'h00, 0, 0); exp(0, 8'h7F, 0, 0);
    exp(1, 8'h90, 0, 1); exp(2, 8'hA2, 1, 0); exp(2, 8'hA2, 0, 0);
    base = hs_count;
    pulse_start();
    while (halted !== 1'b1 && n < 200) begin
      if (hs_count == base + 1) zero_tbl[0] = 1'b0;
      if (hs_count == base + 5) neg_tbl[2] = 1'b0;
      tick();
      n++;
    end
    wait_halt(4'd3, "wrap");
  endtask

  task automatic test_stall();
    int n = 0;
    clear_env();
    mem[0] = 8'h13; mem[1] = 8'h24;
    exp(0, 8'h13, 0, 0); exp(1, 8'h24, 0, 0);
    ins_ready = 1'b0;
    pulse_start();
    while (ins_valid !== 1'b1 && n < 10) begin tick(); n++; end
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);  // start during ISSUE is ignored
      tick();
      total++;
      if (ins_valid !== 1'b1 || prog_count !== 4'd0 || ir !== 8'h13) begin
        bad++;
        $display("FAIL stall_hold: got v=%b pc=%0d ir=%h exp 1 0 13", ins_valid, prog_count, ir);
      end
    end
    start = 1'b0;
    ins_ready = 1'b1;
    wait_halt(4'd2, "stall");
  endtask

  task automatic test_reset_mid_issue();
    int base;
    int n = 0;
    clear_env();
    mem[0] = 8'h00; mem[1] = 8'h01; mem[2] = 8'h1A;
    exp(0, 8'h00, 0, 0); exp(1, 8'h01, 0, 0);
    base = hs_count;
    pulse_start();
    while (hs_count < base + 2 && n < 20) begin tick(); n++; end
    ins_ready = 1'b0;
    tick();
    total++;
    if (ins_valid !== 1'b1 || prog_count !== 4'd2) begin
      bad++;
      $display("FAIL midrst_pre: got v=%b pc=%0d exp 1 2", ins_valid, prog_count);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({prog_count, ir, ins_valid, halted, branch_taken, illegal_op} !== 18'd0) begin
      bad++;
      $display("FAIL midrst_async: got pc=%0d ir=%h v=%b h=%b tk=%b il=%b exp all 0",
               prog_count, ir, ins_valid, halted, branch_taken, illegal_op);
    end
    tick();
    rst = 1'b0;
    ins_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (ins_valid !== 1'b0 || prog_count !== 4'd0 || ir !== 8'h00) begin
        bad++;
        $display("FAIL midrst_idle: got v=%b pc=%0d ir=%h exp 0 0 00", ins_valid, prog_count, ir);
      end
    end
    exp(0, 8'h00, 0, 0); exp(1, 8'h01, 0, 0); exp(2, 8'h1A, 0, 0);
    pulse_start();
    wait_halt(4'd3, "midrst");
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'hF0; regs[i] = 8'h00; zero_tbl[i] = 1'b0; neg_tbl[i] = 1'b0;
    end
    test_reset();
    test_linear();
    test_jump_zero();
    test_jump_neg();
    test_wrap_illegal_self();
    test_stall();
    test_reset_mid_issue();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
